seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 8-digit, common-anode, active-low seven-segment display.
- Holds a 32-bit hex value and an 8-bit per-digit enable mask, and cycles through digits 0..7.
- Inserts a ghost-suppression blanking interval before each digit.
- New values enter through a valid/ready write port and take effect only at frame boundaries, so the display never tears.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 112 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the seven-segment scan controller.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t       SEG_BLANK = 7'h7F;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    typedef enum logic {BLANK, SHOW} scan_state_t;

    // Active-low {a..g}, indexed by hex nibble.
    localparam seg_t GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low glyph.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    assign seg = GLYPH[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 8-digit multiplexed seven-segment scanner with blanking and
// frame-synchronous value updates through a valid/ready write port.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_mask,
    output logic [6:0]  segments,
    output logic [7:0]  anode,
    output logic [2:0]  digit_idx,
    output logic        frame_done
);

    localparam int TMAX = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CW   = $clog2((TMAX > 2) ? TMAX : 2);
    localparam logic [CW-1:0] D_LAST = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] B_LAST = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

    scan_state_t   state, st_nxt;
    logic [2:0]    dig_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   act_data, act_data_nxt, shd_data;
    logic [7:0]    act_mask, act_mask_nxt, shd_mask;
    logic          pending;
    logic          wr_acc;
    logic          lit_nxt;
    seg_t          glyph;

    assign wr_ready = ~pending;
    assign wr_acc   = wr_valid & ~pending;

    always_comb begin
        st_nxt  = state;
        dig_nxt = digit_idx;
        cnt_nxt = cnt + 1'b1;
        unique case (state)
            BLANK: begin
                if (BLANK_TICKS == 0 || cnt == B_LAST) begin
                    st_nxt  = SHOW;
                    cnt_nxt = '0;
                end
            end
            SHOW: begin
                if (cnt == D_LAST) begin
                    dig_nxt = digit_idx + 3'd1;
                    cnt_nxt = '0;
                    st_nxt  = (BLANK_TICKS == 0) ? SHOW : BLANK;
                end
            end
            default: st_nxt = BLANK;
        endcase
    end

    // frame_done marks the boundary cycle; the swap lands on the edge ending it,
    // so outputs for the following cycle must already see the new active value.
    always_comb begin
        act_data_nxt = act_data;
        act_mask_nxt = act_mask;
        if (frame_done && pending) begin
            act_data_nxt = shd_data;
            act_mask_nxt = shd_mask;
        end
    end

    assign lit_nxt = (st_nxt == SHOW) && act_mask_nxt[dig_nxt];

    seg7_hex_decode u_dec (
        .nib (act_data_nxt[{dig_nxt, 2'b00} +: 4]),
        .seg (glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            digit_idx  <= '0;
            cnt        <= '0;
            act_data   <= '0;
            act_mask   <= '0;
            shd_data   <= '0;
            shd_mask   <= '0;
            pending    <= 1'b0;
            segments   <= SEG_BLANK;
            anode      <= ANODE_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= st_nxt;
            digit_idx  <= dig_nxt;
            cnt        <= cnt_nxt;
            act_data   <= act_data_nxt;
            act_mask   <= act_mask_nxt;
            segments   <= lit_nxt ? glyph : SEG_BLANK;
            anode      <= lit_nxt ? ~(8'b1 << dig_nxt) : ANODE_OFF;
            frame_done <= (st_nxt == SHOW) && (dig_nxt == 3'd7) && (cnt_nxt == D_LAST);
            // A write taken on the boundary cycle only fills the shadow.
            if (wr_acc) begin
                shd_data <= wr_data;
                shd_mask <= wr_mask;
                pending  <= 1'b1;
            end else if (frame_done && pending) begin
                pending  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl against a slot-arithmetic reference model.
module tb_seg7_scan_ctrl;

    localparam int DT = 4;
    localparam int BT = 2;
    localparam int SLOT = DT + BT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic [7:0]  wr_mask = '0;
    logic [6:0]  segments;
    logic [7:0]  anode;
    logic [2:0]  digit_idx;
    logic        frame_done;

    logic        w1_valid = 1'b1;
    logic        w1_ready;
    logic [31:0] w1_data = '0;
    logic [7:0]  w1_mask = 8'hFF;
    logic [6:0]  seg1;
    logic [7:0]  an1;
    logic [2:0]  dig1;
    logic        fd1;

    int n_chk  = 0;
    int n_fail = 0;

    int          t;
    logic [31:0] m_act_d, m_shd_d;
    logic [7:0]  m_act_m, m_shd_m;
    bit          m_pend;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_mask(wr_mask), .segments(segments),
        .anode(anode), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    seg7_scan_ctrl #(.DIGIT_TICKS(1), .BLANK_TICKS(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr_valid(w1_valid), .wr_ready(w1_ready),
        .wr_data(w1_data), .wr_mask(w1_mask), .segments(seg1),
        .anode(an1), .digit_idx(dig1), .frame_done(fd1)
    );

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic bit is_fd(input int tt);
        return (tt % SLOT == SLOT - 1) && ((tt / SLOT) % 8 == 7);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_act_d = '0; m_act_m = '0;
        m_shd_d = '0; m_shd_m = '0;
        m_pend  = 1'b0;
    endtask

    // Check all outputs for cycle t, advance the model, then move to the next cycle.
    task automatic step();
        int d, d1;
        bit lit, fd, on, lit1;
        logic [7:0] ea, ea1;
        logic [6:0] es;
        d   = (t / SLOT) % 8;
        lit = (t % SLOT) >= BT;
        fd  = is_fd(t);
        on  = lit && m_act_m[d];
        ea  = on ? ~(8'b1 << d) : 8'hFF;
        es  = on ? glyph(m_act_d[d*4 +: 4]) : 7'h7F;
        chk("anode", {24'h0, anode}, {24'h0, ea});
        chk("segments", {25'h0, segments}, {25'h0, es});
        chk("digit_idx", {29'h0, digit_idx}, d);
        chk("frame_done", {31'h0, frame_done}, {31'h0, fd});
        chk("wr_ready", {31'h0, wr_ready}, {31'h0, !m_pend});

        lit1 = t >= 1;
        d1   = lit1 ? (t - 1) % 8 : 0;
        ea1  = (lit1 && t >= 9) ? ~(8'b1 << d1) : 8'hFF;
        chk("fast_anode", {24'h0, an1}, {24'h0, ea1});
        chk("fast_frame_done", {31'h0, fd1}, {31'h0, lit1 && d1 == 7});

        if (wr_valid && !m_pend) begin
            m_shd_d = wr_data;
            m_shd_m = wr_mask;
            m_pend  = 1'b1;
        end else if (fd && m_pend) begin
            m_act_d = m_shd_d;
            m_act_m = m_shd_m;
            m_pend  = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold a write until the model says it was taken; bounded wait.
    task automatic do_write(input logic [31:0] d, input logic [7:0] m);
        bit acc;
        int guard;
        wr_valid = 1'b1; wr_data = d; wr_mask = m;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            acc = !m_pend;
            step();
            guard++;
        end
        if (!acc) chk("write_timeout", 32'h0, 32'h1);
        wr_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_anode", {24'h0, anode}, 32'hFF);
        chk("rst_segments", {25'h0, segments}, 32'h7F);
        chk("rst_digit", {29'h0, digit_idx}, 32'h0);
        chk("rst_ready", {31'h0, wr_ready}, 32'h1);
        chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
        rst_n = 1'b1;

        // Full mask, known digits
        do_write(32'h76543210, 8'hFF);
        run(2 * 8 * SLOT);

        // Alternate digits masked
        do_write($urandom, 8'b10101010);
        run(2 * 8 * SLOT);

        // Mid-frame write, then a second one that must stall
        while ((t % (8 * SLOT)) != 20) step();
        do_write(32'hFFFFFFFF, 8'hFF);
        do_write(32'h12345678, 8'h0F);
        run(8 * SLOT + 10);

        // Write landing exactly on the frame_done cycle
        while (m_pend) step();
        while (!is_fd(t)) step();
        wr_valid = 1'b1; wr_data = 32'hFEDCBA98; wr_mask = 8'hFF;
        step();
        wr_valid = 1'b0;
        run(2 * 8 * SLOT + 4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            wr_valid = ($urandom_range(0, 9) == 0);
            wr_data  = $urandom;
            wr_mask  = 8'($urandom);
            step();
        end
        wr_valid = 1'b0;

        // Reset during digit 5 with a write pending
        while (m_pend) step();
        while ((t / SLOT) % 8 != 1) step();
        do_write($urandom, 8'hFF);
        while (!((t / SLOT) % 8 == 5 && (t % SLOT) >= BT + 1)) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_anode", {24'h0, anode}, 32'hFF);
        chk("mid_rst_segments", {25'h0, segments}, 32'h7F);
        chk("mid_rst_digit", {29'h0, digit_idx}, 32'h0);
        chk("mid_rst_ready", {31'h0, wr_ready}, 32'h1);
        chk("mid_rst_fast_anode", {24'h0, an1}, 32'hFF);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(8 * SLOT + 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
